display_framebuffer: RTL

//   Double-buffered pixel store directly upstream of display_driver. Answers the

---
 rtl/display_framebuffer_pkg.sv | 17 +
 rtl/display_framebuffer_bank_ram.sv | 35 +++
 rtl/display_framebuffer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/display_framebuffer_pkg.sv
// Shared types and elaboration helpers for the double-buffered framebuffer.
package display_framebuffer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fb_state_e;

  // Address width for v entries, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/display_framebuffer_bank_ram.sv
// Simple dual-port RAM holding both banks of one scan segment.
// Registered read port, with a resettable output register and a forced-zero read.
module framebuffer_bank_ram #(
  parameter int DEPTH = 512,
  parameter int DW    = 24,
  parameter int AW    = 9
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  input  logic          rzero_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write port: storage is not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read port: one-cycle latency; out-of-range fetches return zero.
  always_ff @(posedge clk_i) begin
    if (rst_i)        rdata_q <= '0;
    else if (rzero_i) rdata_q <= '0;
    else              rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/display_framebuffer.sv
// Double-buffered pixel store: front bank feeds the display driver, host writes
// land in the back bank, banks swap only on frame_complete, and a clear engine
// zero-fills the back bank one entry per clock.
module display_framebuffer
  import display_framebuffer_pkg::*;
#(
  parameter int segments = 1,
  parameter int rows     = 8,
  parameter int columns  = 32,
  parameter int bitwidth = 8,
  localparam int RW = clog2_min1(rows),
  localparam int CW = clog2_min1(columns),
  localparam int SW = clog2_min1(segments * rows),
  localparam int PW = 3 * bitwidth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RW-1:0]          row,
  input  logic [CW-1:0]          column,
  output logic [segments*PW-1:0] pixel,
  input  logic                   frame_complete,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [SW-1:0]          wr_row,
  input  logic [CW-1:0]          wr_column,
  input  logic [PW-1:0]          wr_data,
  input  logic                   flip_req,
  output logic                   flip_pending,
  output logic                   flip_done,
  input  logic                   clear_req,
  output logic                   clear_busy
);

  localparam int NPIX = rows * columns;        // entries per bank per segment
  localparam int NTOT = segments * NPIX;       // clear walk length
  localparam int AW   = clog2_min1(2 * NPIX);  // bank is the upper half of each RAM
  localparam int CNTW = clog2_min1(NTOT);

  fb_state_e             state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic                  front_q, front_d;
  logic                  pend_q, pend_d;
  logic                  done_q;
  logic                  idle, swap, clr_we, wr_ok, rzero;
  logic [AW-1:0]         waddr, raddr;
  logic [PW-1:0]         wdata;
  logic [segments-1:0]   seg_we;
  int                    wr_seg, wr_lrow;

  assign idle         = (state_q == ST_IDLE);
  assign wr_ready     = idle;
  assign clear_busy   = ~idle;
  assign flip_pending = pend_q;
  assign flip_done    = done_q;

  // A swap is only safe at a frame boundary and never while the back bank is being cleared.
  assign swap = frame_complete & (pend_q | flip_req) & idle;

  // Flip bookkeeping: a request is held until a safe swap takes it.
  always_comb begin
    front_d = front_q;
    pend_d  = pend_q | flip_req;
    if (swap) begin
      front_d = ~front_q;
      pend_d  = 1'b0;
    end
  end

  // Flip state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      front_q <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      front_q <= front_d;
      pend_q  <= pend_d;
      done_q  <= swap;
    end
  end

  // Clear engine: walk the counter once over the panel, writing zeros.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (cnt_q == CNTW'(NTOT - 1)) state_d = ST_IDLE;
        else                          cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear engine state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write decode: absolute panel row selects the segment RAM; clear hits every
  // segment at the same local address, so all banks are zero by the end of the walk.
  always_comb begin
    wr_seg  = int'(wr_row) / rows;
    wr_lrow = int'(wr_row) % rows;
    wr_ok   = wr_valid & idle & (int'(wr_row) < segments * rows) & (int'(wr_column) < columns);
    if (clr_we) begin
      waddr = AW'((front_q ? 0 : NPIX) + (int'(cnt_q) % NPIX));
      wdata = '0;
    end else begin
      waddr = AW'((front_q ? 0 : NPIX) + wr_lrow * columns + int'(wr_column));
      wdata = wr_data;
    end
    seg_we = '0;
    for (int s = 0; s < segments; s++) seg_we[s] = clr_we | (wr_ok & (wr_seg == s));
  end

  // Read decode: same local address in every segment, taken from the front bank.
  always_comb begin
    rzero = (int'(row) >= rows) || (int'(column) >= columns);
    raddr = rzero ? '0 : AW'((front_q ? NPIX : 0) + int'(row) * columns + int'(column));
  end

  for (genvar s = 0; s < segments; s++) begin : g_seg
    framebuffer_bank_ram #(
      .DEPTH (2 * NPIX),
      .DW    (PW),
      .AW    (AW)
    ) u_ram (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (seg_we[s]),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .raddr_i (raddr),
      .rzero_i (rzero),
      .rdata_o (pixel[s*PW +: PW])
    );
  end

endmodule
